// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes and the execute-unit FSM state type.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_MOVZ = 4'b0100;
  localparam logic [3:0] ALU_DIV  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LSL  = 4'b1000;
  localparam logic [3:0] ALU_LSR  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the execute stage and alu_exec.
interface alu_exec_if #(parameter int WIDTH = 4);
  logic             start;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             div_by_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, alucontrol, a, b,
    input  result, zero, carry, div_by_zero, busy, done
  );

  modport slave (
    input  start, alucontrol, a, b,
    output result, zero, carry, div_by_zero, busy, done
  );
endinterface

// File: rtl/alu_exec_divider.sv
// alu_divider: unsigned restoring divider, one quotient bit per step.
// quotient/remainder show the outcome of the step in progress so the final bit can be captured on the last step edge.
module alu_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] rem_p1, quo_p1, dvs_p1;
  logic [WIDTH:0]   trial_p0;
  logic [WIDTH-1:0] diff_p0;
  logic             ge_p0;

  // Shift the next dividend bit into the partial remainder and trial-subtract
  assign trial_p0  = {rem_p1, quo_p1[WIDTH-1]};
  assign ge_p0     = (trial_p0 >= {1'b0, dvs_p1});
  assign diff_p0   = trial_p0[WIDTH-1:0] - dvs_p1;
  assign remainder = ge_p0 ? diff_p0 : trial_p0[WIDTH-1:0];
  assign quotient  = {quo_p1[WIDTH-2:0], ge_p0};

  // Stage p1: partial remainder, dividend/quotient shift register, divisor
  always_ff @(posedge clk) begin
    if (load) begin
      rem_p1 <= '0;
      quo_p1 <= dividend;
      dvs_p1 <= divisor;
    end else if (step) begin
      rem_p1 <= remainder;
      quo_p1 <= quotient;
    end
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: multicycle execute unit; single-cycle ops plus an optional iterative DIV.
// Define ALU_EXEC_DIV_EN to build the divider and DIV state; otherwise DIV is an unsupported code.
module alu_exec
  import cpu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);
  logic [WIDTH:0]          add_p0, sub_p0;
  logic signed [WIDTH-1:0] sa_p0, sb_p0;
  logic [WIDTH-1:0]        res_p0, cap_res;
  logic                    carry_p0, dbz_p0, cap_carry, cap_dbz, cap;
  alu_state_t              state, state_n;

  assign add_p0 = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_p0 = {1'b0, bus.a} - {1'b0, bus.b};
  assign sa_p0  = bus.a;
  assign sb_p0  = bus.b;

  // Stage p0: single-cycle operation mux
  always_comb begin
    res_p0   = '0;
    carry_p0 = 1'b0;
    dbz_p0   = 1'b0;
    case (bus.alucontrol)
      ALU_ADD:  {carry_p0, res_p0} = add_p0;
      ALU_SUB:  begin
        res_p0   = sub_p0[WIDTH-1:0];
        carry_p0 = ~sub_p0[WIDTH];
      end
      ALU_AND:  res_p0 = bus.a & bus.b;
      ALU_OR:   res_p0 = bus.a | bus.b;
      ALU_MOVZ: res_p0 = bus.b;
`ifdef ALU_EXEC_DIV_EN
      ALU_DIV:  if (bus.b == '0) begin
        res_p0 = '1;
        dbz_p0 = 1'b1;
      end
`endif
      ALU_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, (sa_p0 < sb_p0)};
      ALU_NOR:  res_p0 = ~(bus.a | bus.b);
      ALU_LSL:  res_p0 = bus.a << bus.b;
      ALU_LSR:  res_p0 = bus.a >> bus.b;
      default:  res_p0 = '0;
    endcase
  end

`ifdef ALU_EXEC_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    cnt;
  logic             div_load, div_step;
  logic [WIDTH-1:0] div_quo, div_rem_unused;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .load      (div_load),
    .step      (div_step),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .quotient  (div_quo),
    .remainder (div_rem_unused)
  );

  always_ff @(posedge clk) begin
    if (reset)         cnt <= '0;
    else if (div_load) cnt <= CW'(WIDTH);
    else if (div_step) cnt <= cnt - CW'(1);
  end

  assign bus.busy = (state == DIV);
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cap       = 1'b0;
    cap_res   = res_p0;
    cap_carry = carry_p0;
    cap_dbz   = dbz_p0;
`ifdef ALU_EXEC_DIV_EN
    div_load  = 1'b0;
    div_step  = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          state_n = DONE;
          cap     = 1'b1;
`ifdef ALU_EXEC_DIV_EN
          if (bus.alucontrol == ALU_DIV && bus.b != '0) begin
            state_n  = DIV;
            cap      = 1'b0;
            div_load = 1'b1;
          end
`endif
        end
      end
`ifdef ALU_EXEC_DIV_EN
      DIV: begin
        div_step = 1'b1;
        if (cnt == CW'(1)) begin
          state_n   = DONE;
          cap       = 1'b1;
          cap_res   = div_quo;
          cap_carry = 1'b0;
          cap_dbz   = 1'b0;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Stage p1: architectural outputs, updated only when entering DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result      <= '0;
      bus.zero        <= 1'b1;
      bus.carry       <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else if (cap) begin
      bus.result      <= cap_res;
      bus.zero        <= (cap_res == '0);
      bus.carry       <= cap_carry;
      bus.div_by_zero <= cap_dbz;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, multi-cycle sequences, random ops vs a reference model.
module tb_alu_exec;
  import cpu_pkg::*;

  localparam int W = 4;
  localparam int M = 1 << W;

`ifdef ALU_EXEC_DIV_EN
  localparam int DQ_13_3 = 4, DQ_15_15 = 1, DLAT = W + 1, DZ_RES = M - 1, DZ_FLAG = 1;
`else
  localparam int DQ_13_3 = 0, DQ_15_15 = 0, DLAT = 1, DZ_RES = 0, DZ_FLAG = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(W)) bus();
  alu_exec #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] op;
    int a; int b; int res; int carry; int dbz; int lat;
  } vec_t;

  typedef struct {int res; int carry; int dbz; int lat;} exp_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [3:0] op, input int a, input int b);
    bus.start      = s;
    bus.alucontrol = op;
    bus.a          = a[W-1:0];
    bus.b          = b[W-1:0];
  endtask

  // Reference model from the operation table, using plain integer arithmetic
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int sa, sb;
    e  = '{0, 0, 0, 1};
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    case (op)
      0: begin e.res = (a + b) % M; e.carry = ((a + b) >= M) ? 1 : 0; end
      1: begin e.res = (a - b + M) % M; e.carry = (a >= b) ? 1 : 0; end
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = b;
`ifdef ALU_EXEC_DIV_EN
      5: if (b == 0) begin e.res = M - 1; e.dbz = 1; end
         else begin e.res = a / b; e.lat = W + 1; end
`endif
      6: e.res = (sa < sb) ? 1 : 0;
      7: e.res = (M - 1) - (a | b);
      8: e.res = (b >= W) ? 0 : (a * (1 << b)) % M;
      9: e.res = (b >= W) ? 0 : a / (1 << b);
      default: e.res = 0;
    endcase
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input int a, input int b,
                        input int e_res, input int e_carry, input int e_dbz, input int e_lat);
    int lat;
    set_in(1'b1, op, a, b);
    tick();
    lat = 1;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < W + 3) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " result"}, 32'(bus.result), 32'(e_res));
    chk({tag, " zero"}, 32'(bus.zero), (e_res == 0) ? 32'd1 : 32'd0);
    chk({tag, " carry"}, 32'(bus.carry), 32'(e_carry));
    chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e_dbz));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " result"}, 32'(bus.result), 32'd0);
    chk({tag, " zero"}, 32'(bus.zero), 32'd1);
    chk({tag, " carry"}, 32'(bus.carry), 32'd0);
    chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int op, a, b;

    vecs[0]  = '{ALU_ADD,  10, 7, 1, 1, 0, 1};
    vecs[1]  = '{ALU_SUB,  3, 5, 14, 0, 0, 1};
    vecs[2]  = '{ALU_SUB,  7, 7, 0, 1, 0, 1};
    vecs[3]  = '{ALU_AND,  12, 10, 8, 0, 0, 1};
    vecs[4]  = '{ALU_SLT,  8, 1, 1, 0, 0, 1};
    vecs[5]  = '{ALU_SLT,  1, 8, 0, 0, 0, 1};
    vecs[6]  = '{ALU_LSL,  3, 2, 12, 0, 0, 1};
    vecs[7]  = '{ALU_LSL,  3, 4, 0, 0, 0, 1};
    vecs[8]  = '{ALU_LSR,  8, 5, 0, 0, 0, 1};
    vecs[9]  = '{ALU_LSR,  8, 3, 1, 0, 0, 1};
    vecs[10] = '{ALU_MOVZ, 5, 9, 9, 0, 0, 1};
    vecs[11] = '{ALU_DIV,  13, 3, DQ_13_3, 0, 0, DLAT};
    vecs[12] = '{ALU_DIV,  9, 0, DZ_RES, 0, DZ_FLAG, 1};
    vecs[13] = '{ALU_DIV,  15, 15, DQ_15_15, 0, 0, DLAT};
    vecs[14] = '{4'b1011,  15, 15, 0, 0, 0, 1};
    vecs[15] = '{ALU_NOR,  0, 0, 15, 0, 0, 1};

    set_in(1'b0, 4'd0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    chk_reset_vals("in reset");
    reset = 1'b0;
    tick();
    chk_reset_vals("idle after reset");

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].carry, vecs[i].dbz, vecs[i].lat);

    // Back-to-back single-cycle ops: done every cycle
    set_in(1'b1, ALU_OR, 11, 4);
    tick();
    chk("b2b or done", 32'(bus.done), 32'd1);
    chk("b2b or result", 32'(bus.result), 32'hF);
    set_in(1'b1, ALU_NOR, 11, 4);
    tick();
    chk("b2b nor done", 32'(bus.done), 32'd1);
    chk("b2b nor result", 32'(bus.result), 32'h0);
    chk("b2b nor zero", 32'(bus.zero), 32'd1);
    set_in(1'b1, ALU_MOVZ, 11, 4);
    tick();
    chk("b2b movz done", 32'(bus.done), 32'd1);
    chk("b2b movz result", 32'(bus.result), 32'h4);
    bus.start = 1'b0;
    tick();
    chk("b2b idle done", 32'(bus.done), 32'd0);
    chk("b2b idle result hold", 32'(bus.result), 32'h4);

`ifdef ALU_EXEC_DIV_EN
    // DIV 13/3 with an ADD request at T+2 that must be dropped
    set_in(1'b1, ALU_DIV, 13, 3);
    for (int c = 1; c <= W + 1; c++) begin
      tick();
      if (c <= W) begin
        chk($sformatf("div seq busy c%0d", c), 32'(bus.busy), 32'd1);
        chk($sformatf("div seq done c%0d", c), 32'(bus.done), 32'd0);
        chk($sformatf("div seq hold c%0d", c), 32'(bus.result), 32'h4);
      end else begin
        chk("div seq final busy", 32'(bus.busy), 32'd0);
        chk("div seq final done", 32'(bus.done), 32'd1);
        chk("div seq quotient", 32'(bus.result), 32'd4);
      end
      set_in(c == 2, ALU_ADD, 1, 1);
    end
    tick();
    chk("ignored add done", 32'(bus.done), 32'd0);
    chk("ignored add result", 32'(bus.result), 32'd4);

    // Reset at T+2 of DIV 15/2 aborts without a done pulse
    run_op("pre-reset add", ALU_ADD, 1, 1, 2, 0, 0, 1);
    set_in(1'b1, ALU_DIV, 15, 2);
    tick();
    bus.start = 1'b0;
    chk("abort c1 busy", 32'(bus.busy), 32'd1);
    tick();
    chk("abort c2 done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("after abort");
    for (int c = 0; c < W + 2; c++) begin
      tick();
      chk($sformatf("no done after abort c%0d", c), 32'(bus.done), 32'd0);
    end
`else
    set_in(1'b1, ALU_DIV, 13, 3);
    tick();
    bus.start = 1'b0;
    chk("div disabled busy", 32'(bus.busy), 32'd0);
    chk("div disabled done", 32'(bus.done), 32'd1);
    chk("div disabled result", 32'(bus.result), 32'd0);
    chk("div disabled dbz", 32'(bus.div_by_zero), 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 15));
      a  = int'($urandom_range(0, M - 1));
      b  = int'($urandom_range(0, M - 1));
      e  = model(op, a, b);
      run_op($sformatf("rnd%0d op%0d a%0d b%0d", i, op, a, b), op[3:0], a, b,
             e.res, e.carry, e.dbz, e.lat);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk($sformatf("rnd%0d idle done", i), 32'(bus.done), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
